// File: rtl/mdu_div.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div
// Brief    : Iterative radix-2 restoring divider (DIV/DIVU) for the E stage.
//            Produces {remainder, quotient} after WIDTH iterations, raises a
//            stall request while busy, and can be cancelled with annul.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 annul,
    output logic                 stall_o,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   rq;        // {partial remainder, quotient/dividend}
    logic [WIDTH-1:0]     divisor;   // |b|
    logic [WIDTH-1:0]     a_raw;     // dividend as presented, for divide-by-zero
    logic                 sign_a;
    logic                 sign_b;
    logic                 sdiv;

    logic                 accept;
    logic                 last_iter;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   step;
    logic [WIDTH-1:0]     quot_fin;
    logic [WIDTH-1:0]     rem_fin;
    logic [WIDTH-1:0]     quot_corr;
    logic [WIDTH-1:0]     rem_corr;

    // Operand magnitudes, one restoring iteration and the sign post-correction.
    always_comb begin
        accept    = (state == ST_IDLE) && start && !annul;
        last_iter = (cnt == CW'(WIDTH - 1));
        mag_a     = (signed_div && a[WIDTH-1]) ? -a : a;
        mag_b     = (signed_div && b[WIDTH-1]) ? -b : b;
        // The shifted-out MSB of the remainder participates in the trial, so
        // the subtraction is WIDTH+1 bits wide and its top bit is the borrow.
        trial     = rq[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            step = {trial[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
        end else begin
            step = {rq[2*WIDTH-2:0], 1'b0};
        end
        quot_fin  = step[WIDTH-1:0];
        rem_fin   = step[2*WIDTH-1:WIDTH];
        quot_corr = (sdiv && (sign_a ^ sign_b)) ? -quot_fin : quot_fin;
        rem_corr  = (sdiv && sign_a) ? -rem_fin : rem_fin;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the stall/ready outputs; annul overrides everything.
    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        ready     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (b == '0) ? ST_DIVZERO : ST_ON;
                    stall_o   = 1'b1;
                end
            end
            ST_DIVZERO: begin
                state_nxt = ST_END;
                stall_o   = 1'b1;
            end
            ST_ON: begin
                if (last_iter) begin
                    state_nxt = ST_END;
                end
                stall_o = 1'b1;
            end
            ST_END: begin
                state_nxt = ST_IDLE;
                ready     = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (annul) begin
            state_nxt = ST_IDLE;
            stall_o   = 1'b0;
            ready     = 1'b0;
        end
        if (rst) begin
            stall_o = 1'b0;
            ready   = 1'b0;
        end
    end

    // Operand capture, iteration datapath and the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rq      <= '0;
            divisor <= '0;
            a_raw   <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            sdiv    <= 1'b0;
            result  <= '0;
        end else if (!annul) begin
            if (accept) begin
                cnt     <= '0;
                rq      <= {{WIDTH{1'b0}}, mag_a};
                divisor <= mag_b;
                a_raw   <= a;
                sign_a  <= signed_div & a[WIDTH-1];
                sign_b  <= signed_div & b[WIDTH-1];
                sdiv    <= signed_div;
            end
            if (state == ST_ON) begin
                rq  <= step;
                cnt <= cnt + CW'(1);
                if (last_iter) begin
                    result <= {rem_corr, quot_corr};
                end
            end
            if (state == ST_DIVZERO) begin
                result <= {a_raw, {WIDTH{1'b1}}};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_div
// Brief    : Scoreboard bench for mdu_div: directed corner cases plus random
//            DIV/DIVU traffic with annul, reset and operand scrambling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_div;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           annul;
    logic           stall_o;
    logic           ready;
    logic [2*W-1:0] result;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_res;
    logic [2*W-1:0] mon_exp;
    int             checks = 0;
    int             errors = 0;

    mdu_div #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .stall_o    (stall_o),
        .ready      (ready),
        .result     (result)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference model: plain integer division, C-style truncation.
    function automatic logic [2*W-1:0] model(input bit sd, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [W-1:0] uq;
        logic [W-1:0] ur;
        if (y == 0) return {x, {W{1'b1}}};
        if (sd) begin
            sx = $signed(x);
            sy = $signed(y);
            q  = sx / sy;
            r  = sx % sy;
            return {r[W-1:0], q[W-1:0]};
        end
        uq = x / y;
        ur = x % y;
        return {ur, uq};
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready actual=%h expected=none at %0t", result, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", result, mon_exp);
                last_res = mon_exp;
            end
        end
    end

    // One divide: start at cycle T, then walk the latency checking stall/ready.
    task automatic run_op(input bit sd, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input int annul_at, input bit scramble, input bit hold_end,
                          input logic [W-1:0] na, input logic [W-1:0] nb);
        int lat;
        int last_k;
        lat    = (bb == 0) ? 2 : W + 1;
        last_k = (annul_at >= 0) ? lat + 1 : lat;
        @(posedge clk); #1;
        start = 1'b1; signed_div = sd; a = aa; b = bb; annul = 1'b0;
        if (annul_at < 0) exp_q.push_back(model(sd, aa, bb));
        @(negedge clk);
        check("stall_start", stall_o, 1);
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            annul = (k == annul_at);
            if (scramble) begin
                a = $urandom; b = $urandom; signed_div = 1'($urandom);
            end
            if (hold_end && k == lat) begin
                start = 1'b1; signed_div = 1'b0; a = na; b = nb;
            end
            @(negedge clk);
            if (annul_at >= 0) begin
                check("ready_annul", ready, 0);
                if (k >= annul_at) check("stall_annul", stall_o, 0);
                else check("stall_busy", stall_o, 1);
            end else begin
                check("ready_latency", ready, (k == lat));
                check("stall_busy", stall_o, (k < lat));
            end
        end
        if (annul_at >= 0) begin
            @(posedge clk); #1;
            annul = 1'b0;
            check("result_kept", result, last_res);
        end
    endtask

    // A divide interrupted by reset: no ready, result cleared.
    task automatic run_rst(input logic [W-1:0] aa, input logic [W-1:0] bb, input int at);
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; a = aa; b = bb; annul = 1'b0;
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst   = (k == at);
            @(negedge clk);
            check("ready_rst", ready, 0);
            if (k >= at) check("stall_rst", stall_o, 0);
        end
        check("result_rst", result, 0);
        last_res = '0;
    endtask

    // Directed corner cases followed by random traffic.
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rsd;
        int           rlat;
        int           rann;

        rst = 1'b1; start = 1'b1; signed_div = 1'b0; a = 32'd5; b = 32'd1; annul = 1'b0;
        last_res = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall_in_reset", stall_o, 0);
        check("ready_in_reset", ready, 0);
        check("result_reset", result, 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("stall_idle", stall_o, 0);
        check("ready_idle", ready, 0);

        // 100/7 with start held through END for the following 9/3.
        run_op(1'b0, 32'd100, 32'd7, -1, 1'b0, 1'b1, 32'd9, 32'd3);
        run_op(1'b0, 32'd9, 32'd3, -1, 1'b0, 1'b0, '0, '0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 1'b0, '0, '0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1, 1'b0, 1'b0, '0, '0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 1'b0, '0, '0);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 1'b0, '0, '0);
        run_op(1'b0, 32'h0000_1234, 32'd0, -1, 1'b0, 1'b0, '0, '0);
        check("result_div0_hold", result, {32'h0000_1234, 32'hFFFF_FFFF});
        run_op(1'b0, 32'd100, 32'd7, 10, 1'b0, 1'b0, '0, '0);
        run_rst(32'd100, 32'd7, 5);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, -1, 1'b1, 1'b0, '0, '0);

        for (int n = 0; n < 150; n++) begin
            rsd = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 100);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 20);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            rlat = (rb == 0) ? 2 : W + 1;
            rann = ($urandom_range(0, 9) == 0) ? $urandom_range(1, rlat - 1) : -1;
            run_op(rsd, ra, rb, rann, 1'($urandom), 1'b0, '0, '0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
